// File: rtl/multdiv_ctrl_if.sv
// Pipeline-side handshake bundle for the multi-cycle multiply/divide sequencer.
// The master drives start pulses and operands; the slave returns result, flags and status.
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Multi-cycle 32-bit signed multiply (shift-add) / divide (restoring) sequencer.
// Iterates on magnitudes one bit per clock, applies the sign in FIX, strobes ready from DONE.
module multdiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clock,
    input  logic          resetn,
    multdiv_ctrl_if.slave bus
);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);
    localparam logic [WIDTH-1:0]   MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;

    logic               start, mul_start, div_zero;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] div_sh;
    logic               fix_neg;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   fix_quot;
    logic [WIDTH-1:0]   fix_res;
    logic               fix_exc;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + ONE_W) : x;
    endfunction

    // Multiply has priority when both start pulses arrive together.
    always_comb begin
        start     = bus.ctrl_MULT | bus.ctrl_DIV;
        mul_start = bus.ctrl_MULT;
        div_zero  = ~bus.ctrl_MULT & bus.ctrl_DIV & (bus.data_operandB == '0);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            res_q    <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    // A start pulse restarts from any state, which is how aborts are realised.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            cnt_d = '0;
            if (mul_start)     state_d = S_MUL;
            else if (div_zero) state_d = S_DONE;
            else               state_d = S_DIV;
        end else begin
            unique case (state_q)
                S_MUL, S_DIV: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
                S_FIX:   state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        mul_addend = acc_q[0] ? mag_a_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

        div_sh = {acc_q[2*WIDTH-2:0], 1'b0};
        if (div_sh[2*WIDTH-1:WIDTH] >= mag_b_q) begin
            div_sh[2*WIDTH-1:WIDTH] = div_sh[2*WIDTH-1:WIDTH] - mag_b_q;
            div_sh[0]               = 1'b1;
        end

        // Zero magnitudes are never negated, so a zero result stays +0.
        fix_neg  = (sign_a_q ^ sign_b_q) &&
                   (is_div_q ? (acc_q[WIDTH-1:0] != '0) : (acc_q != '0));
        fix_prod = fix_neg ? (~acc_q + ONE_2W) : acc_q;
        fix_quot = fix_neg ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
        if (is_div_q) begin
            fix_res = fix_quot;
            fix_exc = sign_a_q & (mag_a_q == MIN_W) & sign_b_q & (mag_b_q == ONE_W);
        end else begin
            fix_res = fix_prod[WIDTH-1:0];
            fix_exc = fix_prod[2*WIDTH-1:WIDTH] != {WIDTH{fix_prod[WIDTH-1]}};
        end

        acc_d    = acc_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        res_d    = res_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        busy_d   = busy_q;

        if (start) begin
            mag_a_d  = abs_val(bus.data_operandA);
            mag_b_d  = abs_val(bus.data_operandB);
            sign_a_d = bus.data_operandA[WIDTH-1];
            sign_b_d = bus.data_operandB[WIDTH-1];
            is_div_d = ~mul_start;
            acc_d    = {{WIDTH{1'b0}}, mul_start ? mag_b_d : mag_a_d};
            exc_d    = 1'b0;
            busy_d   = 1'b1;
            if (div_zero) begin
                res_d = '0;
                exc_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_MUL: acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                S_DIV: acc_d = div_sh;
                S_FIX: begin
                    res_d = fix_res;
                    exc_d = fix_exc;
                end
                S_DONE: begin
                    rdy_d  = 1'b1;
                    busy_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: vector table, corner-case sequences and
// randomized operations against an arithmetic reference model.
module tb_multdiv_ctrl;
    logic clock  = 1'b0;
    logic resetn = 1'b0;

    multdiv_ctrl_if #(.WIDTH(32)) bus();

    multdiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          m;
        bit          d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        bus.ctrl_MULT     = m;
        bus.ctrl_DIV      = d;
        bus.data_operandA = a;
        bus.data_operandB = b;
        tick();
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic watch(input int n, output int first, output int strobes,
                         output logic [31:0] res, output logic exc);
        first   = -1;
        strobes = 0;
        res     = '0;
        exc     = 1'b0;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (bus.data_resultRDY === 1'b1) begin
                strobes++;
                if (first < 0) begin
                    first = k;
                    res   = bus.data_result;
                    exc   = bus.data_exception;
                end
            end
        end
    endtask

    function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        longint p;
        int     lo, qa, qb;
        qa = a;
        qb = b;
        if (m) begin
            p   = longint'(qa) * longint'(qb);
            lo  = int'(p[31:0]);
            r   = p[31:0];
            e   = (p != longint'(lo));
            lat = 34;
        end else if (b == 32'h0) begin
            r = '0; e = 1'b1; lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000; e = 1'b1; lat = 34;
        end else begin
            r = 32'(qa / qb); e = 1'b0; lat = 34;
        end
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 1000));
            6: return 32'(-$signed(32'($urandom_range(1, 1000))));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          first, strobes, bad;
        logic [31:0] r, er;
        logic        e, ee;
        int          el;
        bit          m;
        logic [31:0] a, b;
        int          offs[3];

        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34};
        vecs[1]  = '{1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 34};
        vecs[2]  = '{1'b0, 1'b1, 32'd5,          32'd0,         32'd0,         1'b1, 1};
        vecs[3]  = '{1'b1, 1'b0, 32'd2,          32'd3,         32'd6,         1'b0, 34};
        vecs[4]  = '{1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 32'h0,         1'b1, 34};
        vecs[5]  = '{1'b1, 1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 34};
        vecs[6]  = '{1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 34};
        vecs[7]  = '{1'b0, 1'b1, 32'd81,         32'd9,         32'd9,         1'b0, 34};
        vecs[8]  = '{1'b1, 1'b1, 32'd6,          32'd3,         32'd18,        1'b0, 34};
        vecs[9]  = '{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 34};
        vecs[10] = '{1'b1, 1'b0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 34};
        vecs[11] = '{1'b0, 1'b1, 32'd0,          32'd5,         32'd0,         1'b0, 34};
        vecs[12] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0, 34};
        vecs[13] = '{1'b0, 1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'd3,         1'b0, 34};
        vecs[14] = '{1'b1, 1'b0, 32'd0,          32'hFFFF_FFFB, 32'd0,         1'b0, 34};

        repeat (2) @(posedge clock);
        #1;
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exc",    32'(bus.data_exception), 32'h0);
        check("reset_rdy",    32'(bus.data_resultRDY), 32'h0);
        check("reset_busy",   32'(bus.busy), 32'h0);
        resetn = 1'b1;
        tick();

        // Busy/ready timing profile of a single multiply.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        bad = 0;
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (bus.busy !== ((k <= 33) ? 1'b1 : 1'b0)) bad++;
            if (bus.data_resultRDY !== ((k == 34) ? 1'b1 : 1'b0)) bad++;
            if (k == 34) check("profile_result", bus.data_result, 32'hFFFF_FFEB);
        end
        check("busy_rdy_profile", 32'(bad), 32'h0);
        repeat (3) tick();

        for (int i = 0; i < 15; i++) begin
            start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
            watch(40, first, strobes, r, e);
            check($sformatf("vec%0d_latency", i), 32'(first), 32'(vecs[i].lat));
            check($sformatf("vec%0d_strobes", i), 32'(strobes), 32'd1);
            check($sformatf("vec%0d_result", i), r, vecs[i].res);
            check($sformatf("vec%0d_exc", i), 32'(e), 32'(vecs[i].exc));
            check($sformatf("vec%0d_hold", i), bus.data_result, vecs[i].res);
        end

        // Exception clears on the next start edge while the result is held.
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        watch(3, first, strobes, r, e);
        check("divzero_exc", 32'(e), 32'h1);
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        check("exc_clear_at_start", 32'(bus.data_exception), 32'h0);
        check("result_held_at_start", bus.data_result, 32'h0);
        watch(40, first, strobes, r, e);
        check("after_divzero_mult", r, 32'd6);

        // Restart mid-step, from FIX and from DONE.
        offs[0] = 10; offs[1] = 33; offs[2] = 34;
        foreach (offs[j]) begin
            start_op(1'b1, 1'b0, 32'd5, 32'd5);
            bad = 0;
            for (int k = 1; k < offs[j]; k++) begin
                tick();
                if (bus.data_resultRDY !== 1'b0) bad++;
            end
            start_op(1'b0, 1'b1, 32'd81, 32'd9);
            if (bus.data_resultRDY !== 1'b0) bad++;
            watch(40, first, strobes, r, e);
            check($sformatf("abort%0d_early_rdy", offs[j]), 32'(bad), 32'h0);
            check($sformatf("abort%0d_strobes", offs[j]), 32'(strobes), 32'd1);
            check($sformatf("abort%0d_latency", offs[j]), 32'(first), 32'd34);
            check($sformatf("abort%0d_result", offs[j]), r, 32'd9);
        end

        // Asynchronous reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd9, 32'd9);
        repeat (14) tick();
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst_result", bus.data_result, 32'h0);
        check("async_rst_busy",   32'(bus.busy), 32'h0);
        check("async_rst_rdy",    32'(bus.data_resultRDY), 32'h0);
        bus.ctrl_MULT     = 1'b1;
        bus.data_operandA = 32'd3;
        bus.data_operandB = 32'd3;
        repeat (2) tick();
        check("start_ignored_in_rst", 32'(bus.busy), 32'h0);
        bus.ctrl_MULT = 1'b0;
        resetn        = 1'b1;
        watch(40, first, strobes, r, e);
        check("rst_no_strobe", 32'(strobes), 32'h0);
        check("rst_idle_busy", 32'(bus.busy), 32'h0);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        watch(40, first, strobes, r, e);
        check("post_rst_div_result", r, 32'h8000_0000);
        check("post_rst_div_exc", 32'(e), 32'h1);

        for (int i = 0; i < 40; i++) begin
            m = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            model(m, a, b, er, ee, el);
            start_op(m, ~m, a, b);
            watch(40, first, strobes, r, e);
            check($sformatf("rnd%0d_%s_%0h_%0h_result", i, m ? "mul" : "div", a, b), r, er);
            check($sformatf("rnd%0d_exc", i), 32'(e), 32'(ee));
            check($sformatf("rnd%0d_latency", i), 32'(first), 32'(el));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
